// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-requester FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_BURST_MAX = 4;
  localparam int unsigned STAT_W        = 16;
  localparam int unsigned BEAT_CNT_W    = 4;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_S0   = 2'b01;
  localparam logic [1:0] OWNER_S1   = 2'b10;

  // State values double as the owner encoding driven on the owner port.
  typedef enum logic [1:0] {
    IDLE = OWNER_IDLE,
    GNT0 = OWNER_S0,
    GNT1 = OWNER_S1
  } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO bundle for fifo_wr_arbiter.
// master: requester + FIFO side; slave: the arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              s0_valid;
  logic [DATA_W-1:0] s0_data;
  logic              s0_ready;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic [1:0]        owner;
  logic [STAT_W-1:0] stat0;
  logic [STAT_W-1:0] stat1;

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, fifo_full,
    input  s0_ready, s1_ready, fifo_wr_en, fifo_wr_data, owner, stat0, stat1
  );

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, fifo_full,
    output s0_ready, s1_ready, fifo_wr_en, fifo_wr_data, owner, stat0, stat1
  );
endinterface

// File: rtl/fifo_arb_sat_cnt.sv
// Saturating up-counter used for per-requester accepted-beat statistics.
module fifo_arb_sat_cnt
  import fifo_arb_pkg::*;
#(
  parameter int unsigned W = STAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count accepted beats, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin burst arbiter writing into a single FIFO.
// Optional statistics counters are built only with FIFO_ARB_STATS_EN defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);

  localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(BURST_MAX);

  state_t                  state, state_nxt;
  logic                    rr_ptr, rr_nxt;
  logic [BEAT_CNT_W-1:0]   beat_cnt, beat_nxt;
  logic [BEAT_CNT_W-1:0]   beat_inc;
  logic                    ready0, ready1;
  logic                    wr_en;
  logic [DATA_W-1:0]       wr_data;

  assign beat_inc = beat_cnt + 1'b1;

  // State, round-robin pointer and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Grant selection, burst termination and handshake outputs.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    beat_nxt  = beat_cnt;
    ready0    = 1'b0;
    ready1    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    unique case (state)
      IDLE: begin
        beat_nxt = '0;
        if (bus.s0_valid && bus.s1_valid) begin
          state_nxt = rr_ptr ? GNT1 : GNT0;
        end else if (bus.s0_valid) begin
          state_nxt = GNT0;
        end else if (bus.s1_valid) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        ready0  = !bus.fifo_full;
        wr_en   = bus.s0_valid && ready0;
        wr_data = bus.s0_data;
        if (wr_en) beat_nxt = beat_inc;
        if (!bus.s0_valid || (wr_en && (beat_inc == BURST_LAST))) begin
          rr_nxt    = 1'b1;
          beat_nxt  = '0;
          state_nxt = bus.s1_valid ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        ready1  = !bus.fifo_full;
        wr_en   = bus.s1_valid && ready1;
        wr_data = bus.s1_data;
        if (wr_en) beat_nxt = beat_inc;
        if (!bus.s1_valid || (wr_en && (beat_inc == BURST_LAST))) begin
          rr_nxt    = 1'b0;
          beat_nxt  = '0;
          state_nxt = bus.s0_valid ? GNT0 : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase
    // Reset masks the handshake immediately so an aborted burst writes nothing.
    if (rst) begin
      ready0 = 1'b0;
      ready1 = 1'b0;
      wr_en  = 1'b0;
    end
  end

  assign bus.s0_ready     = ready0;
  assign bus.s1_ready     = ready1;
  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_wr_data = wr_data;
  assign bus.owner        = rst ? OWNER_IDLE : state;

`ifdef FIFO_ARB_STATS_EN
  logic acc0, acc1;
  assign acc0 = bus.s0_valid && ready0;
  assign acc1 = bus.s1_valid && ready1;

  fifo_arb_sat_cnt #(.W(STAT_W)) u_stat0 (
    .clk (clk),
    .rst (rst),
    .inc (acc0),
    .cnt (bus.stat0)
  );

  fifo_arb_sat_cnt #(.W(STAT_W)) u_stat1 (
    .clk (clk),
    .rst (rst),
    .inc (acc1),
    .cnt (bus.stat1)
  );
`else
  assign bus.stat0 = '0;
  assign bus.stat1 = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter (DATA_W=8, BURST_MAX=4).
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
module tb_fifo_wr_arbiter;

  typedef struct {
    logic       rst;
    logic       s0v;
    logic [7:0] s0d;
    logic       s1v;
    logic [7:0] s1d;
    logic       full;
    logic       e_r0;
    logic       e_r1;
    logic       e_wr;
    logic [7:0] e_d;
    logic [1:0] e_own;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_W(8)) bus ();

  fifo_wr_arbiter #(.DATA_W(8), .BURST_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t v(input logic r, input logic s0v, input logic [7:0] s0d,
                             input logic s1v, input logic [7:0] s1d, input logic full,
                             input logic e_r0, input logic e_r1, input logic e_wr,
                             input logic [7:0] e_d, input logic [1:0] e_own);
    vec_t t;
    t.rst = r; t.s0v = s0v; t.s0d = s0d; t.s1v = s1v; t.s1d = s1d; t.full = full;
    t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_wr = e_wr; t.e_d = e_d; t.e_own = e_own;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst           = t.rst;
    bus.s0_valid  = t.s0v;
    bus.s0_data   = t.s0d;
    bus.s1_valid  = t.s1v;
    bus.s1_data   = t.s1d;
    bus.fifo_full = t.full;
    #1;
    chk($sformatf("%s.s0_ready", tag), 32'(bus.s0_ready), 32'(t.e_r0));
    chk($sformatf("%s.s1_ready", tag), 32'(bus.s1_ready), 32'(t.e_r1));
    chk($sformatf("%s.wr_en", tag), 32'(bus.fifo_wr_en), 32'(t.e_wr));
    chk($sformatf("%s.owner", tag), 32'(bus.owner), 32'(t.e_own));
    if (t.e_wr) chk($sformatf("%s.wr_data", tag), 32'(bus.fifo_wr_data), 32'(t.e_d));
  endtask

  vec_t tbl[$];
  vec_t hs[$];

  initial begin
    bus.s0_valid  = 1'b0;
    bus.s0_data   = '0;
    bus.s1_valid  = 1'b0;
    bus.s1_data   = '0;
    bus.fifo_full = 1'b0;

    //                  rst s0v s0d    s1v s1d    full r0 r1 wr data   owner
    // reset state
    tbl.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    tbl.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    // s0 only, three beats, 1-cycle latency, then IDLE
    tbl.push_back(v(0, 1, 8'hA1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 1, 8'hA1, 0, 8'h00, 0, 1, 0, 1, 8'hA1, 2'b01));
    tbl.push_back(v(0, 1, 8'hA2, 0, 8'h00, 0, 1, 0, 1, 8'hA2, 2'b01));
    tbl.push_back(v(0, 1, 8'hA3, 0, 8'h00, 0, 1, 0, 1, 8'hA3, 2'b01));
    tbl.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b01));
    tbl.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    // reset to rr_ptr=0, then both valid: 4 from s0, 4 from s1, 4 from s0
    tbl.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 1, 8'hB0, 1, 8'hC0, 0, 0, 0, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 1, 8'hB0, 1, 8'hC0, 0, 1, 0, 1, 8'hB0, 2'b01));
    tbl.push_back(v(0, 1, 8'hB1, 1, 8'hC0, 0, 1, 0, 1, 8'hB1, 2'b01));
    tbl.push_back(v(0, 1, 8'hB2, 1, 8'hC0, 0, 1, 0, 1, 8'hB2, 2'b01));
    tbl.push_back(v(0, 1, 8'hB3, 1, 8'hC0, 0, 1, 0, 1, 8'hB3, 2'b01));
    tbl.push_back(v(0, 1, 8'hB4, 1, 8'hC0, 0, 0, 1, 1, 8'hC0, 2'b10));
    tbl.push_back(v(0, 1, 8'hB4, 1, 8'hC1, 0, 0, 1, 1, 8'hC1, 2'b10));
    tbl.push_back(v(0, 1, 8'hB4, 1, 8'hC2, 0, 0, 1, 1, 8'hC2, 2'b10));
    tbl.push_back(v(0, 1, 8'hB4, 1, 8'hC3, 0, 0, 1, 1, 8'hC3, 2'b10));
    tbl.push_back(v(0, 1, 8'hB4, 1, 8'hC4, 0, 1, 0, 1, 8'hB4, 2'b01));
    tbl.push_back(v(0, 1, 8'hB5, 1, 8'hC4, 0, 1, 0, 1, 8'hB5, 2'b01));
    tbl.push_back(v(0, 1, 8'hB6, 1, 8'hC4, 0, 1, 0, 1, 8'hB6, 2'b01));
    tbl.push_back(v(0, 1, 8'hB7, 1, 8'hC4, 0, 1, 0, 1, 8'hB7, 2'b01));
    // s1 granted, fifo_full for 5 cycles mid-burst, resumes at held data
    tbl.push_back(v(0, 0, 8'h00, 1, 8'hD0, 0, 0, 1, 1, 8'hD0, 2'b10));
    tbl.push_back(v(0, 0, 8'h00, 1, 8'hD1, 0, 0, 1, 1, 8'hD1, 2'b10));
    for (int unsigned i = 0; i < 5; i++)
      tbl.push_back(v(0, 0, 8'h00, 1, 8'hD2, 1, 0, 0, 0, 8'h00, 2'b10));
    tbl.push_back(v(0, 0, 8'h00, 1, 8'hD2, 0, 0, 1, 1, 8'hD2, 2'b10));
    tbl.push_back(v(0, 0, 8'h00, 1, 8'hD3, 0, 0, 1, 1, 8'hD3, 2'b10));
    tbl.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    // s0 drops after 2 beats with s1 pending: no idle bubble
    tbl.push_back(v(0, 1, 8'hE0, 1, 8'hF0, 0, 0, 0, 0, 8'h00, 2'b00));
    tbl.push_back(v(0, 1, 8'hE0, 1, 8'hF0, 0, 1, 0, 1, 8'hE0, 2'b01));
    tbl.push_back(v(0, 1, 8'hE1, 1, 8'hF0, 0, 1, 0, 1, 8'hE1, 2'b01));
    tbl.push_back(v(0, 0, 8'h00, 1, 8'hF0, 0, 1, 0, 0, 8'h00, 2'b01));
    tbl.push_back(v(0, 0, 8'h00, 1, 8'hF0, 0, 0, 1, 1, 8'hF0, 2'b10));
    tbl.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 2'b10));
    tbl.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-burst: first leave rr_ptr=1, then reset during beat 2 of an
    // s0 burst; a following simultaneous request must go to s0.
    hs.push_back(v(0, 1, 8'h11, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    hs.push_back(v(0, 1, 8'h11, 0, 8'h00, 0, 1, 0, 1, 8'h11, 2'b01));
    hs.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b01));
    hs.push_back(v(0, 1, 8'h21, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    hs.push_back(v(0, 1, 8'h21, 0, 8'h00, 0, 1, 0, 1, 8'h21, 2'b01));
    hs.push_back(v(1, 1, 8'h22, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    hs.push_back(v(0, 1, 8'h31, 1, 8'h41, 0, 0, 0, 0, 8'h00, 2'b00));
    hs.push_back(v(0, 1, 8'h31, 1, 8'h41, 0, 1, 0, 1, 8'h31, 2'b01));
    hs.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'b01));
    hs.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00));
    foreach (hs[i]) apply(hs[i], $sformatf("rstseq%0d", i));

`ifdef FIFO_ARB_STATS_EN
    begin
      int unsigned beats = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("stat0_after_rst", 32'(bus.stat0), 32'h0);
      chk("stat1_after_rst", 32'(bus.stat1), 32'h0);
      bus.s0_valid = 1'b1;
      bus.s0_data  = 8'h5A;
      for (int unsigned c = 0; c < 95000 && beats < 70000; c++) begin
        @(negedge clk);
        #1;
        if (bus.fifo_wr_en) beats++;
      end
      chk("stat_beats_done", beats, 32'd70000);
      @(negedge clk);
      bus.s0_valid = 1'b0;
      #1;
      chk("stat0_saturated", 32'(bus.stat0), 32'hFFFF);
      chk("stat1_zero", 32'(bus.stat1), 32'h0);
    end
`else
    @(negedge clk);
    #1;
    chk("stat0_tied", 32'(bus.stat0), 32'h0);
    chk("stat1_tied", 32'(bus.stat1), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
